// File: rtl/pix_stream_pkg.sv
// pix_stream_pkg: shared constants, FSM states, pixel+tag type and SRAM address composition
package pix_stream_pkg;
  localparam int ADDR_SZ = 20;
  localparam int PIX_W = 24;
  localparam int RAM_WIDTH = 32;
  typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [23:0] data;
    logic        eol;
  } pix_t;
  function automatic logic [ADDR_SZ-1:0] pix_addr(input logic [7:0] y, input logic [7:0] x);
    return {{(ADDR_SZ-16){1'b0}}, y, x};
  endfunction
endpackage

// File: rtl/pix_skid_buf.sv
// pix_skid_buf: output register plus a one-entry skid that catches the read landing during a stall
module pix_skid_buf
  import pix_stream_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  pix_t in_pix,
  input  logic hold,
  output logic out_valid,
  output pix_t out_pix,
  output logic skid_empty
);
  pix_t out_q, out_d, skid_q, skid_d;
  logic out_v_q, out_v_d, skid_v_q, skid_v_d;
  always_comb begin
    out_v_d = hold ? out_v_q : (skid_v_q | in_valid);
    out_d = hold ? out_q : skid_v_q ? skid_q : in_valid ? in_pix : out_q;
    skid_v_d = hold & (skid_v_q | in_valid);
    skid_d = (hold & in_valid) ? in_pix : skid_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_q <= '0;
      out_v_q <= 1'b0;
      skid_q <= '0;
      skid_v_q <= 1'b0;
    end else begin
      out_q <= out_d;
      out_v_q <= out_v_d;
      skid_q <= skid_d;
      skid_v_q <= skid_v_d;
    end
  assign out_valid = out_v_q;
  assign out_pix = out_q;
  assign skid_empty = ~skid_v_q;
endmodule

// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: reads a frame from SRAM in row-major order and emits a stallable pixel stream
module pixel_stream_tx #(
  parameter int ADDR_SZ = pix_stream_pkg::ADDR_SZ,
  parameter int PIX_W = pix_stream_pkg::PIX_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                go,
  input  logic [7:0]                          width_m1,
  input  logic [7:0]                          height_m1,
  input  logic                                hold,
  output logic                                mem_rd_en,
  output logic [ADDR_SZ-1:0]                  mem_addr,
  input  logic [pix_stream_pkg::RAM_WIDTH-1:0] mem_rdata,
  output logic                                start_out,
  output logic                                valid_out,
  output logic [PIX_W-1:0]                    data_out,
  output logic                                jump_out,
  output logic                                busy,
  output logic                                frame_done
);
  import pix_stream_pkg::*;
  state_t state_q, state_d;
  logic [7:0] x_q, x_d, y_q, y_d, wm1_q, wm1_d, hm1_q, hm1_d;
  logic fly_q, fly_d, eol_q, eol_d;
  logic rd, x_end, last, out_valid, skid_empty, unused_hi;
  pix_t rd_pix, out_pix;
  assign x_end = x_q == wm1_q;
  assign last = x_end && y_q == hm1_q;
  // the skid drains whenever hold is low, so a new read may issue in that same cycle
  assign rd = state_q == START || (state_q == STREAM && !hold);
  always_comb begin
    state_d = state_q;
    wm1_d = wm1_q;
    hm1_d = hm1_q;
    x_d = rd ? (x_end ? 8'd0 : x_q + 8'd1) : x_q;
    y_d = (rd && x_end) ? y_q + 8'd1 : y_q;
    fly_d = rd;
    eol_d = x_end;
    case (state_q)
      IDLE: if (go) begin
        state_d = START;
        wm1_d = width_m1;
        hm1_d = height_m1;
        x_d = 8'd0;
        y_d = 8'd0;
      end
      START: state_d = last ? DRAIN : STREAM;
      STREAM: if (rd && last) state_d = DRAIN;
      DRAIN: if (!fly_q && skid_empty && !(out_valid && hold)) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      wm1_q <= '0;
      hm1_q <= '0;
      fly_q <= 1'b0;
      eol_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      wm1_q <= wm1_d;
      hm1_q <= hm1_d;
      fly_q <= fly_d;
      eol_q <= eol_d;
    end
  assign rd_pix = '{data: mem_rdata[23:0], eol: eol_q};
  assign unused_hi = ^mem_rdata[31:24];
  pix_skid_buf u_skid (
    .clk(clk),
    .rst(rst),
    .in_valid(fly_q),
    .in_pix(rd_pix),
    .hold(hold),
    .out_valid(out_valid),
    .out_pix(out_pix),
    .skid_empty(skid_empty)
  );
  assign mem_rd_en = rd;
  assign mem_addr = ADDR_SZ'(pix_addr(y_q, x_q));
  assign start_out = state_q == START;
  assign busy = state_q != IDLE;
  assign frame_done = state_q == DONE;
  assign valid_out = out_valid;
  assign data_out = PIX_W'(out_pix.data);
  assign jump_out = out_valid & out_pix.eol;
endmodule
